pack32to128: RTL and testbench

Input packer for the AES datapath. It collects four 32-bit words from a valid/ready stream into one 128-bit block and presents that block with a valid/ready handshake. The block feeds the cipher state register and the 128-to-32 word splitter, so word lane order matches that splitter: the first word accepted lands in [31:0] (w0) and the fourth in [127:96] (w3).

---
 rtl/pack32to128.sv | 124 ++++++++++++
 tb/tb_pack32to128.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pack32to128.sv
// pack32to128: input packer for the AES datapath.
// Collects four 32-bit words from a valid/ready stream into one 128-bit block.
// Lane order: the first accepted word lands in [31:0], the fourth in [127:96].
// Build option: define PACK_DOUBLE_BUF_EN to decouple the assembly register
// from the output register. Without it, a single-buffer FILL/FULL machine is used.
module pack32to128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [31:0]  in_word,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   word_cnt
);

  // Words 0..2 are held here; word 3 goes straight into the output register
  // together with these lanes, so a partially written block never reaches out_block.
  logic [95:0]  asm_q, asm_d;
  logic [1:0]   word_cnt_q, word_cnt_d;
  logic [127:0] out_block_q, out_block_d;
  logic         in_accept;
  logic         transfer;
  logic         consume;

`ifdef PACK_DOUBLE_BUF_EN
  logic out_valid_q, out_valid_d;

  // Words 0..2 always fit; word 3 needs the output register free or being freed now.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && !clr) begin
      in_ready = (word_cnt_q != 2'd3) || !out_valid_q || out_ready;
    end
  end

  // Output valid: a transfer in the same cycle as a consume keeps it set.
  always_comb begin
    out_valid_d = out_valid_q;
    if (consume) out_valid_d = 1'b0;
    if (transfer) out_valid_d = 1'b1;
  end

  // Output valid register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid_q <= 1'b0;
    else     out_valid_q <= out_valid_d;
  end

  assign out_valid = out_valid_q;
`else
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Ready depends only on registered state (plus rst/clr gating), never on out_ready.
  always_comb begin
    in_ready = !rst && !clr && (state_q == FILL);
  end

  // Next state: the fourth accept fills the buffer, a consume empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (transfer) state_d = FULL;
      FULL:    if (consume)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  assign out_valid = (state_q == FULL);
`endif

  // Datapath next-state: lane writes, word counter, and block transfer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    asm_d       = asm_q;
    word_cnt_d  = word_cnt_q;
    out_block_d = out_block_q;
    in_accept   = in_valid && in_ready;
    transfer    = in_accept && (word_cnt_q == 2'd3);
    consume     = out_valid && out_ready;
    if (clr) begin
      word_cnt_d = 2'd0;
    end else if (in_accept) begin
      word_cnt_d = word_cnt_q + 2'd1;
      case (word_cnt_q)
        2'd0:    asm_d[31:0]  = in_word;
        2'd1:    asm_d[63:32] = in_word;
        2'd2:    asm_d[95:64] = in_word;
        default: out_block_d  = {in_word, asm_q};
      endcase
    end
  end

  // Datapath registers; rst returns everything to zero immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      asm_q       <= '0;
      word_cnt_q  <= 2'd0;
      out_block_q <= '0;
    end else begin
      asm_q       <= asm_d;
      word_cnt_q  <= word_cnt_d;
      out_block_q <= out_block_d;
    end
  end

  assign out_block = out_block_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_pack32to128.sv
// Self-checking bench for pack32to128: directed scenarios plus random traffic,
// checked by a word-list reference model and a scoreboard of expected blocks.
module tb_pack32to128;

`ifdef PACK_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic [31:0]  in_word = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] out_block;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   word_cnt;

  pack32to128 dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: words collected so far, blocks awaiting consumption.
  logic [31:0]  part_q[$];
  logic [127:0] exp_q[$];
  bit           out_full = 1'b0;

  // Monitor/scoreboard: compares DUT against the model mid-cycle, then advances
  // the model by what the next rising edge will do.
  always @(negedge clk) begin
    bit exp_rdy;
    if (rst) begin
      part_q.delete();
      exp_q.delete();
      out_full = 1'b0;
    end else begin
      if (DBL) exp_rdy = !clr && (part_q.size() < 3 || !out_full || out_ready);
      else     exp_rdy = !clr && !out_full;
      check("in_ready", 128'(in_ready), 128'(exp_rdy));
      check("out_valid", 128'(out_valid), 128'(out_full));
      check("word_cnt", 128'(word_cnt), 128'(part_q.size()));
      if (out_full) check("out_block", out_block, exp_q[0]);
      if (out_full && out_ready) begin
        void'(exp_q.pop_front());
        out_full = 1'b0;
      end
      if (clr) part_q.delete();
      else if (in_valid && exp_rdy) part_q.push_back(in_word);
      if (part_q.size() == 4) begin
        exp_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
        part_q.delete();
        out_full = 1'b1;
      end
    end
  end

  // One clock of stimulus; reports whether a word was accepted / a block consumed.
  task automatic step(input bit v, input logic [31:0] w, input bit ordy, input bit c,
                      output bit acc, output bit cons);
    in_valid  = v;
    in_word   = w;
    out_ready = ordy;
    clr       = c;
    @(negedge clk);
    acc  = in_valid && in_ready;
    cons = out_valid && out_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input bit ordy);
    bit a, c;
    int n = 0;
    do begin
      step(1'b1, w, ordy, 1'b0, a, c);
      n++;
    end while (!a && n < 50);
    check("send_accept", 128'(a), 128'(1'b1));
  endtask

  task automatic idle(input int n);
    bit a, c;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, a, c);
  endtask

  // Asynchronous reset pulse raised mid-cycle; outputs must clear before any clock edge.
  task automatic pulse_reset();
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_out_block", out_block, 128'h0);
    check("rst_word_cnt", 128'(word_cnt), 128'(2'd0));
    check("rst_in_ready", 128'(in_ready), 128'(1'b0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit a, c;
    int n_acc, n_cyc, n_cons;

    // Reset state.
    #3;
    check("init_out_valid", 128'(out_valid), 128'(1'b0));
    check("init_out_block", out_block, 128'h0);
    check("init_word_cnt", 128'(word_cnt), 128'(2'd0));
    check("init_in_ready", 128'(in_ready), 128'(1'b0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic block, consumer always ready.
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b1);
    check("blk1_valid", 128'(out_valid), 128'(1'b1));
    check("blk1_value", out_block, 128'h00000004_00000003_00000002_00000001);
    check("blk1_cnt", 128'(word_cnt), 128'(2'd0));
    step(1'b0, 32'h0, 1'b1, 1'b0, a, c);
    check("blk1_one_cycle", 128'(out_valid), 128'(1'b0));

    // Output stall: block must hold; single buffer takes nothing, double takes 3.
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, a, c);
      if (a) n_acc++;
    end
    check("stall_accepts", 128'(n_acc), DBL ? 128'd3 : 128'd0);
    check("stall_block", out_block, 128'h00000004_00000003_00000002_00000001);

    // Reset while out_valid is high.
    pulse_reset();

    // clr drops the partial block and the word offered with it.
    send(32'h1111_1111, 1'b1);
    send(32'h2222_2222, 1'b1);
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, a, c);
    check("clr_drop", 128'(a), 128'(1'b0));
    check("clr_cnt", 128'(word_cnt), 128'(2'd0));
    for (int i = 0; i < 4; i++) send(32'hC0DE_0000 + 32'(i), 1'b1);
    check("clr_block", out_block, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);
    idle(2);

    // Throughput: 8 words, continuous valid, consumer always ready.
    n_acc = 0;
    n_cyc = 0;
    n_cons = 0;
    while (n_acc < 8 && n_cyc < 40) begin
      step(1'b1, 32'h5000_0000 + 32'(n_acc), 1'b1, 1'b0, a, c);
      n_cyc++;
      if (a) n_acc++;
      if (c) n_cons++;
    end
    check("tput_accept_cycles", 128'(n_cyc), DBL ? 128'd8 : 128'd9);
    while (n_cons < 2 && n_cyc < 40) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, a, c);
      n_cyc++;
      if (c) n_cons++;
    end
    check("tput_total_cycles", 128'(n_cyc), DBL ? 128'd9 : 128'd10);

    // Reset while word_cnt = 2.
    send(32'h7777_0000, 1'b1);
    send(32'h7777_0001, 1'b1);
    check("pre_rst_cnt", 128'(word_cnt), 128'(2'd2));
    pulse_reset();

    // Random traffic with occasional clr, checked by the monitor.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 20) == 0, a, c);
    end
    idle(3);
    check("drain_empty", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
